// File: rtl/fifo_rd_fwft_if.sv
// Stream and FIFO read-port bundle for the first-word-fall-through adapter.
// master: the adapter side (pops the FIFO, drives the stream).
// slave:  the environment side (FIFO memory/pointer logic and stream sink).
interface fifo_rd_fwft_if #(
    parameter int unsigned DATASIZE = 8
);
    logic                rempty;
    logic [DATASIZE-1:0] rdata;
    logic                rinc;
    logic                m_valid;
    logic [DATASIZE-1:0] m_data;
    logic                m_ready;
    logic [1:0]          rd_level;

    modport master (
        input  rempty, rdata, m_ready,
        output rinc, m_valid, m_data, rd_level
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rinc, m_valid, m_data, rd_level
    );
endinterface

// File: rtl/fifo_rd_fwft.sv
// Read-side first-word-fall-through adapter for the async FIFO.
// Pops the registered-read FIFO memory and holds up to two returned words
// in head/tail registers, presenting head as a full-throughput valid/ready
// stream.
module fifo_rd_fwft #(
    parameter int unsigned DATASIZE = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    fifo_rd_fwft_if.master        bus
);

    logic [1:0]          occ_q, occ_d;
    logic                inflight_q, inflight_d;
    logic [DATASIZE-1:0] head_q, head_d;
    logic [DATASIZE-1:0] tail_q, tail_d;
    logic                pop;
    logic                rinc;
    logic [2:0]          owed;

    // Pop/issue decision and next buffer contents.
    always_comb begin
        pop        = (occ_q != 2'd0) && bus.m_ready;
        // Words owned after this cycle: held + arriving - leaving; 3 bits so it never wraps.
        owed       = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
        rinc       = rrst_n && !bus.rempty && (owed < 3'd2);
        occ_d      = owed[1:0];
        inflight_d = rinc;
        head_d     = head_q;
        tail_d     = tail_q;
        if (inflight_q) begin
            unique case (occ_q)
                2'd0: head_d = bus.rdata;
                2'd1: begin
                    if (pop) head_d = bus.rdata;
                    else     tail_d = bus.rdata;
                end
                2'd2: begin
                    // Only legal with pop: tail advances to head, new word refills tail.
                    if (pop) begin
                        head_d = tail_q;
                        tail_d = bus.rdata;
                    end
                end
                default: ;
            endcase
        end else if (pop && occ_q == 2'd2) begin
            head_d = tail_q;
        end
    end

    // Buffer state registers with synchronous active-low reset.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // A returning word must never find the buffer full and stalled.
    always_ff @(posedge rclk) begin
        if (rrst_n) begin
            assert (!(occ_q == 2'd2 && inflight_q && !pop));
        end
    end

    assign bus.rinc     = rinc;
    assign bus.m_valid  = (occ_q != 2'd0);
    assign bus.m_data   = head_q;
    assign bus.rd_level = occ_q;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Self-checking bench for fifo_rd_fwft: FIFO memory and stream sink modelled
// with queues, expected stream order and buffer level tracked by counting.
module tb_fifo_rd_fwft;

    localparam int unsigned DW = 8;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;

    fifo_rd_fwft_if #(.DATASIZE(DW)) bus ();

    fifo_rd_fwft #(.DATASIZE(DW)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus.master)
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem[$];     // words still in the FIFO memory
    logic [DW-1:0] exp_q[$];   // words not yet delivered, in write order
    bit            pend_v = 1'b0;
    logic [DW-1:0] pend_d = '0;
    int            level_m = 0;
    int            cyc = 0;
    int            rinc_cnt = 0;
    int            xfer_cnt = 0;
    int            first_x = 0;
    int            last_x = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic clear_counts();
        rinc_cnt = 0;
        xfer_cnt = 0;
        first_x  = 0;
        last_x   = 0;
        cyc      = 0;
    endtask

    // One read-clock cycle: drive inputs after the edge, sample mid-cycle, advance model.
    // ready_mode: 0 = hold off, 1 = always accept, 2 = random accept.
    task automatic step(input int ready_mode, input bit rst);
        bit pop;
        bit exp_rinc;
        @(posedge rclk);
        #1;
        rrst_n      = !rst;
        bus.rempty  = (mem.size() == 0);
        bus.rdata   = pend_v ? pend_d : DW'($urandom);
        bus.m_ready = (ready_mode == 0) ? 1'b0 :
                      (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        #4;
        if (rst) begin
            chk("rinc_in_reset", 32'(bus.rinc), 32'd0);
            mem.delete();
            exp_q.delete();
            pend_v     = 1'b0;
            level_m    = 0;
            prev_stall = 1'b0;
        end else begin
            pop = bus.m_valid && bus.m_ready;
            chk("level", 32'(bus.rd_level), 32'(level_m));
            chk("valid", 32'(bus.m_valid), 32'(level_m != 0));
            exp_rinc = !bus.rempty && ((level_m + int'(pend_v) - int'(pop)) < 2);
            chk("rinc", 32'(bus.rinc), 32'(exp_rinc));
            if (prev_stall && bus.m_valid)
                chk("hold", 32'(bus.m_data), 32'(prev_data));
            if (pop) begin
                if (exp_q.size() != 0) begin
                    chk("data", 32'(bus.m_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end else begin
                    chk("data_extra", 32'(bus.m_valid), 32'd0);
                end
                if (xfer_cnt == 0) first_x = cyc;
                last_x = cyc;
                xfer_cnt++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            level_m    = level_m + int'(pend_v) - int'(pop);
            if (bus.rinc) begin
                rinc_cnt++;
                pend_v = 1'b1;
                pend_d = (mem.size() != 0) ? mem.pop_front() : DW'($urandom);
            end else begin
                pend_v = 1'b0;
            end
        end
        cyc++;
    endtask

    initial begin
        int pushed;
        bus.rempty  = 1'b1;
        bus.rdata   = '0;
        bus.m_ready = 1'b0;

        // Reset, then idle with an empty FIFO.
        step(1, 1'b1);
        step(1, 1'b1);
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            step(2, 1'b0);
            chk("idle_data", 32'(bus.m_data), 32'd0);
        end
        chk("idle_rinc_cnt", 32'(rinc_cnt), 32'd0);

        // Single word: first-word latency.
        clear_counts();
        push_word(8'hA5);
        for (int i = 0; i < 6; i++) begin
            step(1, 1'b0);
            chk("single_rinc", 32'(bus.rinc), 32'(i == 0));
            chk("single_valid", 32'(bus.m_valid), 32'(i == 2));
            if (i == 2) chk("single_data", 32'(bus.m_data), 32'hA5);
        end

        // Sixteen words at full rate.
        clear_counts();
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        for (int i = 0; i < 24; i++) step(1, 1'b0);
        chk("burst_xfers", 32'(xfer_cnt), 32'd16);
        chk("burst_span", 32'(last_x - first_x), 32'd15);
        chk("burst_rinc", 32'(rinc_cnt), 32'd16);

        // Eight words under initial backpressure.
        clear_counts();
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        for (int i = 0; i < 6; i++) step(0, 1'b0);
        chk("stall_level", 32'(bus.rd_level), 32'd2);
        chk("stall_rinc", 32'(rinc_cnt), 32'd2);
        chk("stall_data", 32'(bus.m_data), 32'h00);
        for (int i = 0; i < 14; i++) step(1, 1'b0);
        chk("resume_xfers", 32'(xfer_cnt), 32'd8);
        chk("resume_span", 32'(last_x - first_x), 32'd7);
        chk("resume_first", 32'(first_x), 32'd6);

        // Random writes and random backpressure.
        clear_counts();
        pushed = 0;
        for (int c = 0; c < 4000 && !(pushed == 200 && exp_q.size() == 0); c++) begin
            if (pushed < 200 && $urandom_range(0, 2) != 0) begin
                push_word(DW'($urandom));
                pushed++;
            end
            step(2, 1'b0);
        end
        chk("rand_left", 32'(exp_q.size()), 32'd0);
        chk("rand_xfers", 32'(xfer_cnt), 32'd200);

        // Reset in the middle of a stream with words buffered and in flight.
        clear_counts();
        for (int i = 0; i < 8; i++) push_word(8'h40 + DW'(i));
        for (int i = 0; i < 3; i++) step(0, 1'b0);
        chk("pre_rst_level", 32'(bus.rd_level), 32'd1);
        step(1, 1'b0);
        chk("pre_rst_level2", 32'(bus.rd_level), 32'd2);
        step(1, 1'b1);
        step(1, 1'b0);
        chk("post_rst_valid", 32'(bus.m_valid), 32'd0);
        chk("post_rst_data", 32'(bus.m_data), 32'd0);
        chk("post_rst_level", 32'(bus.rd_level), 32'd0);
        clear_counts();
        for (int i = 0; i < 5; i++) push_word(8'hC0 + DW'(i));
        for (int i = 0; i < 12; i++) step(1, 1'b0);
        chk("post_rst_xfers", 32'(xfer_cnt), 32'd5);
        chk("post_rst_first", 32'(first_x), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_fwft.md
# fifo_rd_fwft

Read-side first-word-fall-through adapter for the async FIFO. It sits in the read clock domain, directly downstream of the dual-port FIFO memory and beside the read-pointer/empty logic. It issues pops (`rinc`) against the memory's one-cycle registered read port and holds up to two returned words. It presents them as a valid/ready stream with registered data and full throughput.

## Interface
- `DATASIZE`, 8, width of the memory data word and the stream data.
- `rclk`  in  1  read-domain clock; all logic on its rising edge.
- `rrst_n`  in  1  reset, synchronous, active-low.
- `rempty`  in  1  FIFO empty flag from the read-pointer logic (registered in that block).
- `rdata`  in  DATASIZE  memory read data. The word popped by `rinc` in cycle N is valid here in cycle N+1 only.
- `rinc`  out  1  pop request to the read-pointer logic; advances `raddr` at the end of the cycle.
- `m_valid`  out  1  stream data valid.
- `m_data`  out  DATASIZE  stream data (head register).
- `m_ready`  in  1  downstream accept; transfer when `m_valid && m_ready`.
- `rd_level`  out  2  words held in the output buffer (0..2).

## Operation
- State:
  - `occ` (0..2, drives `rd_level`).
  - `inflight` (1 bit: `rinc` was issued last cycle).
  - `head` and `tail` data registers.
- `pop = m_valid && m_ready`. `m_valid = (occ != 0)`. `m_data = head`.
- Issue rule, combinational:
  - `rinc = rrst_n && !rempty && (occ + inflight - pop) < 2`.
  - Use at least 3-bit arithmetic so the sum never wraps.
- `inflight <= rinc` each cycle.
- Capture when `inflight`; `rdata` is written:
  - into `head` if `occ==0`, or if `occ==1 && pop`;
  - else into `tail` if `occ==1 && !pop`, or if `occ==2 && pop` (the latter case also moves `tail` into `head`).
  - `occ==2 && !pop && inflight` is impossible by the issue rule. An assertion must flag it.
- Pop without capture: if `occ==2`, `head <= tail`. `tail` keeps its stale value (don't-care).
- `occ` update: `occ_next = occ + inflight - pop`.
- `head` is not modified while `m_valid && !m_ready`, except by the rules above, which never touch it in that case. `m_data` is stable under backpressure.
- `rempty` is trusted. Once issued, `rinc` always returns a word one cycle later; no cancel path.

## Timing
- Reset, synchronous on `rclk` while `rrst_n==0`:
  - `occ=0`, `inflight=0`, `head=0`, `tail=0`.
  - `m_valid=0`, `m_data=0`, `rd_level=0`.
  - `rinc` is forced 0 combinationally while reset is asserted.
- Reset mid-operation: any in-flight word and buffered words are discarded. The read-pointer logic is reset on the same `rrst_n`.
- First-word latency: `rempty` falls in cycle 0, then:
  - `rinc=1` in cycle 0;
  - `rdata` valid in cycle 1;
  - `m_valid=1` with the word in cycle 2.
- Throughput: with `m_ready` held high and the FIFO non-empty, one word per cycle after the first.
- Backpressure:
  - With `m_ready=0`, at most 2 words are buffered. `rinc` stops once `occ + inflight == 2`.
  - Full rate resumes the cycle `m_ready` returns, with no bubble.
- Drain: when `rempty` rises, already-issued words still arrive and are delivered in order. No further `rinc` is issued.
- Ordering: strict FIFO order; no word is dropped or duplicated.

## Test plan
- Reset, then leave FIFO empty with `rempty=1` for 10 cycles:
  - `rinc=0`, `m_valid=0`, `m_data=0`, `rd_level=0` throughout.
- Write a single word 0xA5, `rempty` falls in cycle 0:
  - `rinc` pulses in cycle 0 only;
  - `m_valid=1`, `m_data=0xA5` in cycle 2;
  - with `m_ready=1`, `m_valid=0` in cycle 3.
- Preload 16 words 0x00..0x0F, `m_ready=1` constant:
  - the 16 words transfer on 16 consecutive cycles, in order;
  - `rinc` is asserted 16 times total.
- Preload 8 words, `m_ready=0` for 6 cycles, then 1:
  - `rd_level` settles at 2 and only 2 `rinc` pulses occur while stalled;
  - `m_data=0x00` is held stable;
  - all 8 words are then delivered in order with no gaps.
- Random `m_ready` (50%), 200 random words, `rempty` driven from a scoreboard model:
  - output sequence matches input;
  - the `occ==2 && inflight && !pop` assertion never fires.
- Assert `rrst_n=0` for one cycle while `rd_level=2` and `inflight=1`:
  - next cycle all outputs are at reset values and `rinc=0` during reset;
  - after reset, newly written words stream correctly starting from the new first word.
